branch_predictor: RTL

- Fetch-side counterpart of the branch comparator.
- The comparator resolves whether a branch is taken in execute. This block predicts that outcome at fetch, then learns from the resolved `br_taken` result.
- Structure: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry, plus misprediction detection and performance counters.
- Sits between the PC register and the execute-stage branch comparator.

---
 rtl/branch_predictor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped BTB with a 2-bit saturating
// counter per entry. It also flags mispredictions and keeps saturating
// performance counters.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [2:0]       upd_br_type,
  input  logic             upd_br_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2:0] BR_NEVER  = 3'b110;
  localparam logic [2:0] BR_ALWAYS = 3'b111;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  logic                f_hit, u_hit;
  logic                counted, mispred;
  logic                wr_en;
  logic [31:0]         wr_target;
  logic [1:0]          wr_ctr;

  // The low two PC bits are always zero for aligned instructions.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign f_tag = fetch_pc[31:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[31:IDX_BITS+2];

  // Combinational lookup. It reads the pre-update table contents.
  always_comb begin
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && ctr_q[f_idx][1];
    pred_target = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
  end

  // Update decision: what to write into upd_pc's entry this cycle.
  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    counted   = upd_valid && (upd_br_type != BR_NEVER);
    mispred   = (upd_pred_taken != upd_br_taken) ||
                (upd_pred_taken && upd_br_taken && (upd_pred_target != upd_target));
    wr_en     = 1'b0;
    wr_target = target_q[u_idx];
    wr_ctr    = ctr_q[u_idx];
    if (counted) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_br_type == BR_ALWAYS) begin
          wr_ctr    = 2'b11;
          wr_target = upd_target;
        end else if (upd_br_taken) begin
          wr_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          wr_target = upd_target;
        end else begin
          wr_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_br_taken) begin
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_ctr    = (upd_br_type == BR_ALWAYS) ? 2'b11 : 2'b10;
      end
    end
  end

  // BTB storage. An allocation overwrites whatever the entry held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      ctr_q[u_idx]    <= wr_ctr;
    end
  end

  // Misprediction pulse and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      mispredict <= counted && mispred;
      if (counted && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_ONE;
      if (counted && mispred && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule
